// File: rtl/pwm_carrier_event_gen_pkg.sv
// Shared timing-manager definitions for the PWM carrier: event mask bit
// positions, default widths and the event masking helper.
package pwm_carrier_event_gen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DIV_W_DEF  = 8;
  localparam int EVT_VALLEY = 0;
  localparam int EVT_PEAK   = 1;

  typedef enum logic [0:0] {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic evt_mask(input logic high, input logic low, input logic [1:0] sel);
    return (high & sel[EVT_PEAK]) | (low & sel[EVT_VALLEY]);
  endfunction

endpackage

// File: rtl/pwm_carrier_event_gen_carrier_prescaler.sv
// Carrier prescaler: emits a tick every div_active+1 clocks. The divisor
// shadow is updated only when the parent strobes load_i.
module carrier_prescaler
  import pwm_carrier_event_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic [DIV_W-1:0] div_active_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_active_q;
  logic [DIV_W-1:0] div_active_d;
  logic             tick_s;

  assign tick_s       = ~clr_i & (cnt_q == div_active_q);
  assign tick_o       = tick_s;
  assign div_active_o = div_active_q;

  // Prescale count and divisor shadow next-state
  always_comb begin
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    if (clr_i) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {DIV_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (load_i) begin
      div_active_d = div_i;
    end else begin
      div_active_d = div_active_q;
    end
  end

  // Prescaler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {DIV_W{1'b0}};
      div_active_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
    end
  end

endmodule

// File: rtl/pwm_carrier_event_gen.sv
// Symmetric triangular PWM carrier with shadowed peak/divisor settings and
// registered single-cycle peak/valley/event pulses.
module pwm_carrier_event_gen
  import pwm_carrier_event_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] carrier_max_i,
  input  logic [DIV_W-1:0] carrier_div_i,
  input  logic [1:0]       event_sel_i,
  output logic [CNT_W-1:0] carrier_o,
  output logic             carrier_dir_o,
  output logic             carrier_high_o,
  output logic             carrier_low_o,
  output logic             event_qualifier_o,
  output logic [CNT_W-1:0] max_active_o
);

  logic [CNT_W-1:0] carrier_q, carrier_d;
  dir_e             dir_q, dir_d;
  logic             high_q, high_d;
  logic             low_q, low_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] max_active_q, max_active_d;
  logic             tick_s;
  logic             load_s;
  logic [CNT_W-1:0] inc_s;
  logic [CNT_W-1:0] dec_s;
  logic [DIV_W-1:0] div_active_s;

  assign inc_s = carrier_q + CNT_W'(1);
  assign dec_s = carrier_q - CNT_W'(1);

  carrier_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (~enable_i),
    .load_i       (load_s),
    .div_i        (carrier_div_i),
    .tick_o       (tick_s),
    .div_active_o (div_active_s)
  );

  // Triangle counter, shadow load strobe and pulse next-state
  always_comb begin
    carrier_d = carrier_q;
    dir_d     = dir_q;
    high_d    = 1'b0;
    low_d     = 1'b0;
    load_s    = 1'b0;
    if (!enable_i) begin
      carrier_d = {CNT_W{1'b0}};
      dir_d     = DIR_UP;
      load_s    = 1'b1;
    end else if (tick_s) begin
      if (max_active_q == {CNT_W{1'b0}}) begin
        // Idle carrier keeps polling the inputs so a new peak starts promptly
        carrier_d = {CNT_W{1'b0}};
        dir_d     = DIR_UP;
        load_s    = 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (carrier_q < max_active_q) begin
          carrier_d = inc_s;
          if (inc_s == max_active_q) begin
            dir_d  = DIR_DOWN;
            high_d = 1'b1;
          end else begin
            dir_d = DIR_UP;
          end
        end else begin
          dir_d = DIR_DOWN;
        end
      end else begin
        if (carrier_q > {CNT_W{1'b0}}) begin
          carrier_d = dec_s;
          if (dec_s == {CNT_W{1'b0}}) begin
            dir_d  = DIR_UP;
            low_d  = 1'b1;
            load_s = 1'b1;
          end else begin
            dir_d = DIR_DOWN;
          end
        end else begin
          dir_d  = DIR_UP;
          load_s = 1'b1;
        end
      end
    end else begin
      carrier_d = carrier_q;
      dir_d     = dir_q;
    end
    evt_d = evt_mask(high_d, low_d, event_sel_i);
  end

  // Peak shadow next-state
  always_comb begin
    if (load_s) begin
      max_active_d = carrier_max_i;
    end else begin
      max_active_d = max_active_q;
    end
  end

  // Carrier, direction, pulse and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_q    <= {CNT_W{1'b0}};
      dir_q        <= DIR_UP;
      high_q       <= 1'b0;
      low_q        <= 1'b0;
      evt_q        <= 1'b0;
      max_active_q <= {CNT_W{1'b0}};
    end else begin
      carrier_q    <= carrier_d;
      dir_q        <= dir_d;
      high_q       <= high_d;
      low_q        <= low_d;
      evt_q        <= evt_d;
      max_active_q <= max_active_d;
    end
  end

  assign carrier_o         = carrier_q;
  assign carrier_dir_o     = dir_q;
  assign carrier_high_o    = high_q;
  assign carrier_low_o     = low_q;
  assign event_qualifier_o = evt_q;
  assign max_active_o      = max_active_q;

endmodule
